// File: rtl/fc_layer_seq.sv
// fc_layer_seq: time-multiplexed fully connected layer (one MAC, weight/bias register files).
// Optional macro RELU_EN: clamp negative neuron results to zero after saturation.
module fc_layer_seq #(
    parameter int Q           = 15,
    parameter int N           = 32,
    parameter int INPUT_SIZE  = 32,
    parameter int OUTPUT_SIZE = 4,
    localparam int AW = $clog2(INPUT_SIZE * OUTPUT_SIZE),
    localparam int JW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic          cfg_sel,
    input  logic [AW-1:0] cfg_addr,
    input  logic [N-1:0]  cfg_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic [JW-1:0] out_index,
    output logic          out_last,
    output logic          busy
);
    localparam int IW = $clog2(INPUT_SIZE);
    localparam int AC = 2 * N + IW + 1;
    localparam int WN = INPUT_SIZE * OUTPUT_SIZE;
    localparam logic [IW-1:0] LAST_I = IW'(INPUT_SIZE - 1);
    localparam logic [JW-1:0] LAST_J = JW'(OUTPUT_SIZE - 1);
    localparam logic signed [AC-1:0] SMAX = {{(AC-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [AC-1:0] SMIN = {{(AC-N+1){1'b1}}, {(N-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD, MAC, BIAS, OUT} state_t;

    state_t               r_state;
    logic [N-1:0]         r_x [INPUT_SIZE];
    logic [N-1:0]         r_w [WN];
    logic [N-1:0]         r_b [OUTPUT_SIZE];
    logic [IW-1:0]        r_cnt;
    logic [AW-1:0]        r_widx;
    logic [JW-1:0]        r_j;
    logic signed [AC-1:0] r_acc;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_out_last;
    logic [N-1:0]         r_out_data;
    logic [JW-1:0]        r_out_index;

    logic                 w_in_hs;
    logic                 w_cfg_ok;
    logic signed [2*N-1:0] w_prod;
    logic [N-1:0]         w_b;
    logic signed [AC-1:0] w_sum;
    logic signed [AC-1:0] w_shr;
    logic [N-1:0]         w_sat;
    logic [N-1:0]         w_res;

    assign w_in_hs  = in_valid && r_in_ready;
    assign w_cfg_ok = cfg_we && (r_state == IDLE);
    // weights are walked in storage order, so one running index serves every neuron
    assign w_prod   = $signed(r_w[r_widx]) * $signed(r_x[r_cnt]);
    assign w_b      = r_b[r_j];
    assign w_sum    = r_acc + {{(AC-N-Q){w_b[N-1]}}, w_b, {Q{1'b0}}};
    assign w_shr    = w_sum >>> Q;
    assign w_sat    = (w_shr > SMAX) ? {1'b0, {(N-1){1'b1}}} :
                      (w_shr < SMIN) ? {1'b1, {(N-1){1'b0}}} : w_shr[N-1:0];
`ifdef RELU_EN
    assign w_res    = w_sat[N-1] ? '0 : w_sat;
`else
    assign w_res    = w_sat;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_index = r_out_index;
    assign out_last  = r_out_last;
    assign busy      = (r_state != IDLE);

    // weight/bias files: written only while idle, out-of-range addresses ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < WN; k++) r_w[k] <= '0;
            for (int k = 0; k < OUTPUT_SIZE; k++) r_b[k] <= '0;
        end else if (w_cfg_ok) begin
            if (!cfg_sel && ({1'b0, cfg_addr} < (AW+1)'(WN))) r_w[cfg_addr] <= cfg_data;
            if (cfg_sel && ({1'b0, cfg_addr} < (AW+1)'(OUTPUT_SIZE))) r_b[cfg_addr[JW-1:0]] <= cfg_data;
        end
    end

    // control FSM: capture vector, accumulate per neuron, add bias, hand result downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_index <= '0;
            r_out_last  <= 1'b0;
            r_cnt       <= '0;
            r_widx      <= '0;
            r_j         <= '0;
            r_acc       <= '0;
            for (int k = 0; k < INPUT_SIZE; k++) r_x[k] <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_in_hs) begin
                        r_x[0]  <= in_data;
                        r_cnt   <= IW'(1);
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    if (w_in_hs) begin
                        r_x[r_cnt] <= in_data;
                        if (r_cnt == LAST_I) begin
                            r_in_ready <= 1'b0;
                            r_cnt      <= '0;
                            r_widx     <= '0;
                            r_j        <= '0;
                            r_acc      <= '0;
                            r_state    <= MAC;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                MAC: begin
                    r_acc  <= r_acc + {{(AC-2*N){w_prod[2*N-1]}}, w_prod};
                    r_widx <= r_widx + 1'b1;
                    if (r_cnt == LAST_I) r_state <= BIAS;
                    else r_cnt <= r_cnt + 1'b1;
                end
                BIAS: begin
                    r_out_data  <= w_res;
                    r_out_valid <= 1'b1;
                    r_out_index <= r_j;
                    r_out_last  <= (r_j == LAST_J);
                    r_state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (r_out_last) begin
                            r_state <= IDLE;
                        end else begin
                            r_j     <= r_j + 1'b1;
                            r_cnt   <= '0;
                            r_acc   <= '0;
                            r_state <= MAC;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_layer_seq.sv
// tb_fc_layer_seq: scoreboard bench for fc_layer_seq against an arithmetic reference model
module tb_fc_layer_seq;
    localparam int Q  = 15;
    localparam int N  = 32;
    localparam int IN = 32;
    localparam int ON = 4;
    localparam int AW = $clog2(IN * ON);
    localparam int JW = (ON > 1) ? $clog2(ON) : 1;

    typedef struct packed {
        logic [N-1:0]  d;
        logic [JW-1:0] j;
        logic          l;
    } exp_t;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          cfg_we = 0;
    logic          cfg_sel = 0;
    logic [AW-1:0] cfg_addr = '0;
    logic [N-1:0]  cfg_data = '0;
    logic          in_valid = 0;
    logic          in_ready;
    logic [N-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 0;
    logic [N-1:0]  out_data;
    logic [JW-1:0] out_index;
    logic          out_last;
    logic          busy;

    int   checks = 0;
    int   errors = 0;
    int   n_rx = 0;
    bit   hold = 0;
    exp_t q[$];

    logic [N-1:0] mw [IN*ON];
    logic [N-1:0] mb [ON];
    logic [N-1:0] dw [IN*ON];
    logic [N-1:0] db [ON];
    logic [N-1:0] vx [IN];

    fc_layer_seq #(.Q(Q), .N(N), .INPUT_SIZE(IN), .OUTPUT_SIZE(ON)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // Reference neuron: exact dot product plus scaled bias, floor-shifted, clamped to N bits
    function automatic logic [N-1:0] ref_neuron(input int j);
        logic signed [127:0] s;
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        s = 0;
        for (int i = 0; i < IN; i++) s = s + $signed(mw[j*IN+i]) * $signed(vx[i]);
        s = s + $signed(mb[j]) * (128'sd1 <<< Q);
        s = s >>> Q;
        hi = (128'sd1 <<< (N-1)) - 1;
        lo = -(128'sd1 <<< (N-1));
        if (s > hi) s = hi;
        if (s < lo) s = lo;
`ifdef RELU_EN
        if (s < 0) s = 0;
`endif
        return s[N-1:0];
    endfunction

    function automatic logic [N-1:0] rsmall();
        int v;
        v = int'($urandom_range(0, 131072)) - 65536;
        return N'(v);
    endfunction

    // output monitor: every downstream handshake is matched against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got data=%h idx=%0d, required no output", out_data, out_index);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_data", {32'd0, out_data}, {32'd0, e.d});
                chk("out_index", 64'(out_index), 64'(e.j));
                chk("out_last", 64'(out_last), 64'(e.l));
            end
            n_rx++;
        end
    end

    // downstream ready: random backpressure unless held low
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = hold ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    task automatic cfg_write(input logic sel, input int addr, input logic [N-1:0] data);
        cfg_we = 1; cfg_sel = sel; cfg_addr = AW'(addr); cfg_data = data;
        if (!busy) begin
            if (sel && addr < ON) mb[addr] = data;
            else if (!sel && addr < IN*ON) mw[addr] = data;
        end
        @(posedge clk); #1;
        cfg_we = 0;
    endtask

    task automatic load_all();
        for (int k = 0; k < IN*ON; k++) cfg_write(0, k, dw[k]);
        for (int k = 0; k < ON; k++) cfg_write(1, k, db[k]);
    endtask

    task automatic send_vector(input bit gaps, input bit sim_wr, input logic [N-1:0] sim_b);
        int t;
        for (int i = 0; i < IN; i++) begin
            if (i == 0 && sim_wr) begin cfg_we = 1; cfg_sel = 1; cfg_addr = '0; cfg_data = sim_b; end
            in_valid = 1; in_data = vx[i];
            t = 0;
            while (!in_ready && t < 500) begin @(posedge clk); #1; t++; end
            if (!in_ready) begin
                checks++; errors++;
                $display("FAIL in_handshake: element %0d never accepted, required in_ready=1", i);
                in_valid = 0; cfg_we = 0;
                return;
            end
            if (i == 0 && sim_wr && !busy) mb[0] = sim_b;
            @(posedge clk); #1;
            in_valid = 0; cfg_we = 0;
            if (gaps) begin @(posedge clk); #1; end
        end
        for (int j = 0; j < ON; j++) q.push_back('{d: ref_neuron(j), j: JW'(j), l: (j == ON-1)});
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((q.size() != 0 || busy) && t < 3000) begin @(posedge clk); #1; t++; end
        checks++;
        if (q.size() != 0 || busy) begin
            errors++;
            $display("FAIL drain: pending=%0d busy=%b, required pending=0 busy=0", q.size(), busy);
            q.delete();
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_data"}, 64'(out_data), 64'd0);
        chk({tag, "_out_index"}, 64'(out_index), 64'd0);
        chk({tag, "_out_last"}, 64'(out_last), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int t;
        int base;
        exp_t head;
        for (int k = 0; k < IN*ON; k++) mw[k] = '0;
        for (int k = 0; k < ON; k++) mb[k] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1;
        @(posedge clk); #1;
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        // unit inputs, half weights, bias j*1.0
        for (int k = 0; k < IN*ON; k++) dw[k] = 32'h0000_4000;
        for (int k = 0; k < ON; k++) db[k] = N'(k * 32'h0000_8000);
        for (int i = 0; i < IN; i++) vx[i] = 32'h0000_8000;
        load_all();
        send_vector(0, 0, '0);
        wait_done();
        send_vector(1, 0, '0);
        wait_done();

        // bias write beyond the neuron count must not alias onto neuron 0
        cfg_write(1, ON, 32'h7777_0000);
        send_vector(0, 0, '0);
        wait_done();

        // bias write concurrent with the first input element is used
        send_vector(0, 1, 32'h0003_0000);
        wait_done();

        // positive and negative saturation
        for (int k = 0; k < IN*ON; k++) dw[k] = 32'h7FFF_FFFF;
        for (int k = 0; k < ON; k++) db[k] = '0;
        for (int i = 0; i < IN; i++) vx[i] = 32'h7FFF_FFFF;
        load_all();
        send_vector(0, 0, '0);
        wait_done();
        for (int i = 0; i < IN; i++) vx[i] = 32'h8000_0001;
        send_vector(0, 0, '0);
        wait_done();

        // negative weights on neuron 0
        for (int k = 0; k < IN*ON; k++) dw[k] = (k < IN) ? 32'hFFFF_8000 : rsmall();
        for (int k = 0; k < ON; k++) db[k] = '0;
        for (int i = 0; i < IN; i++) vx[i] = 32'h0000_8000;
        load_all();
        send_vector(0, 0, '0);
        wait_done();

        // random weights, biases and inputs
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < IN*ON; k++) dw[k] = rsmall();
            for (int k = 0; k < ON; k++) db[k] = ($urandom_range(0, 1) != 0) ? N'($urandom()) : rsmall();
            for (int i = 0; i < IN; i++) vx[i] = rsmall();
            load_all();
            send_vector(bit'($urandom_range(0, 1)), 0, '0);
            wait_done();
        end

        // backpressure with a dropped configuration write while busy
        hold = 1;
        for (int i = 0; i < IN; i++) vx[i] = rsmall();
        send_vector(0, 0, '0);
        t = 0;
        while (!out_valid && t < 200) begin @(posedge clk); #1; t++; end
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_busy", 64'(busy), 64'd1);
        cfg_write(0, 0, 32'h1234_5678);
        head = (q.size() != 0) ? q[0] : '0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("bp_hold", {out_valid, in_ready, busy, out_index, out_data},
                {1'b1, 1'b0, 1'b1, head.j, head.d});
        end
        hold = 0;
        wait_done();
        send_vector(0, 0, '0);
        wait_done();

        // reset while neuron 1 is accumulating
        for (int k = 0; k < IN*ON; k++) dw[k] = rsmall();
        for (int k = 0; k < ON; k++) db[k] = rsmall();
        for (int i = 0; i < IN; i++) vx[i] = rsmall();
        load_all();
        base = n_rx;
        send_vector(0, 0, '0);
        t = 0;
        while (n_rx == base && t < 500) begin @(posedge clk); #1; t++; end
        chk("rst_first_out", 64'(n_rx - base), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("rst_busy_before", 64'(busy), 64'd1);
        rst_n = 0;
        #1;
        chk_reset_outputs("midrst");
        q.delete();
        for (int k = 0; k < IN*ON; k++) mw[k] = '0;
        for (int k = 0; k < ON; k++) mb[k] = '0;
        @(posedge clk); #1;
        rst_n = 1;
        send_vector(0, 0, '0);
        wait_done();
        for (int k = 0; k < IN*ON; k++) dw[k] = rsmall();
        for (int k = 0; k < ON; k++) db[k] = rsmall();
        load_all();
        send_vector(1, 0, '0);
        wait_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
